uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter through a send/Tx_ready handshake.
// Characters are buffered in a circular store and handed over one at a time.
module uart_tx_fifo #(
    parameter int WORD_LENGHT = 8,
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGHT-1:0] wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [WORD_LENGHT-1:0] Tx_in,
    output logic                   send,
    input  logic                   Tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]             state;
    logic [WORD_LENGHT-1:0] mem [DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic                   pop;
    logic                   push;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Pop decision uses the pre-edge count, so a fresh write waits one edge.
    assign pop  = (state == IDLE) && !empty && Tx_ready;
    assign push = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            send  <= 1'b0;
            Tx_in <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        Tx_in <= mem[rd_ptr];
                        send  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!Tx_ready) begin
                        send  <= 1'b0;
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (Tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    send  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a write-order scoreboard
// and a small behavioural model of occupancy, overflow and handshake state.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] Tx_in;
    logic       send;
    logic       Tx_ready;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    int         mcount = 0;
    bit         movf = 1'b0;
    int         mst = 0;
    logic [7:0] last_tx = 8'h00;
    logic       prev_send = 1'b0;
    int         n_rx = 0;

    uart_tx_fifo #(.WORD_LENGHT(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .Tx_in    (Tx_in),
        .send     (send),
        .Tx_ready (Tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model from pre-edge inputs, then check outputs.
    task automatic tick();
        bit pop_m;
        bit wr_m;
        if (rst) begin
            sb.delete();
            mcount  = 0;
            movf    = 1'b0;
            mst     = 0;
            last_tx = 8'h00;
        end else begin
            pop_m = (mst == 0) && (mcount != 0) && (Tx_ready === 1'b1);
            wr_m  = wr_en && ((mcount != 16) || pop_m);
            if (wr_en && !wr_m) movf = 1'b1;
            if (wr_m) sb.push_back(wr_data);
            mcount = mcount + int'(wr_m) - int'(pop_m);
            case (mst)
                0: if (pop_m) mst = 1;
                1: if (!Tx_ready) mst = 2;
                2: if (Tx_ready) mst = 0;
                default: mst = 0;
            endcase
        end
        @(posedge clk);
        #1;
        chk("count", count, mcount);
        chk("full", full, mcount == 16);
        chk("empty", empty, mcount == 0);
        chk("overflow", overflow, movf);
        chk("send", send, mst == 1);
        if (send && !prev_send) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL unexpected_char: observed %0h expected none", Tx_in);
            end else begin
                last_tx = sb.pop_front();
                n_rx++;
            end
        end
        chk("tx_in", Tx_in, last_tx);
        prev_send = send;
    endtask

    // Handshaking transmitter: drop Tx_ready while send is high, raise it after.
    task automatic drain(input int exp_rx);
        int start;
        int cyc;
        start = n_rx;
        cyc = 0;
        wr_en = 1'b0;
        while (!(mcount == 0 && mst == 0 && n_rx - start >= exp_rx)
               && cyc < 2000) begin
            Tx_ready = !send;
            tick();
            cyc++;
        end
        chk("drain_rx", n_rx - start, exp_rx);
        chk("drain_empty", empty, 1'b1);
    endtask

    initial begin
        int wi;
        int rx0;
        int phase;
        int t;
        int cyc;

        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        Tx_ready = 1'b1;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_send", send, 1'b0);
        chk("rst_txin", Tx_in, 8'h00);
        rst = 1'b0;

        // single byte
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("single_pre_send", send, 1'b0);
        chk("single_pre_count", count, 1);
        tick();
        chk("single_send", send, 1'b1);
        chk("single_txin", Tx_in, 8'hA5);
        Tx_ready = 1'b0;
        tick();
        chk("single_send_clr", send, 1'b0);
        Tx_ready = 1'b1;
        tick();
        tick();
        chk("single_idle_send", send, 1'b0);
        chk("single_empty", empty, 1'b1);

        // fill past full with transmitter stalled
        Tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 16);
        chk("fill_overflow", overflow, 1'b1);
        drain(16);
        chk("ovf_sticky", overflow, 1'b1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // simultaneous write and pop at full
        Tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h20 + i);
            tick();
        end
        Tx_ready = 1'b1;
        wr_data = 8'h30;
        tick();
        wr_en = 1'b0;
        chk("simfull_count", count, 16);
        chk("simfull_full", full, 1'b1);
        chk("simfull_ovf", overflow, 1'b0);
        chk("simfull_txin", Tx_in, 8'h20);
        drain(16);

        // simultaneous write and pop at count=1
        Tx_ready = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h41;
        tick();
        Tx_ready = 1'b1;
        wr_data = 8'h42;
        tick();
        wr_en = 1'b0;
        chk("sim1_count", count, 1);
        chk("sim1_txin", Tx_in, 8'h41);
        drain(1);

        // streaming with a slow transmitter, pointers wrap
        wi = 0;
        rx0 = n_rx;
        phase = 0;
        t = 0;
        cyc = 0;
        Tx_ready = 1'b1;
        while (!(n_rx - rx0 == 40 && mcount == 0 && mst == 0) && cyc < 4000) begin
            wr_en = (wi < 40) && (mcount < 15);
            wr_data = 8'(8'h80 + wi);
            if (wr_en) wi++;
            tick();
            cyc++;
            case (phase)
                0: if (send) begin phase = 1; t = 0; end
                1: begin
                    t++;
                    if (t == 3) begin Tx_ready = 1'b0; phase = 2; t = 0; end
                end
                default: begin
                    t++;
                    if (t == 20) begin Tx_ready = 1'b1; phase = 0; end
                end
            endcase
        end
        wr_en = 1'b0;
        chk("stream_rx", n_rx - rx0, 40);
        chk("stream_empty", empty, 1'b1);

        // reset while a character is in flight
        Tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h50 + i);
            tick();
        end
        wr_en = 1'b0;
        Tx_ready = 1'b1;
        tick();
        chk("midrst_pre_send", send, 1'b1);
        chk("midrst_pre_count", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_send", send, 1'b0);
        chk("midrst_txin", Tx_in, 8'h00);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1'b1);
        wr_en = 1'b1;
        wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        chk("post_rst_nosend", send, 1'b0);
        tick();
        chk("post_rst_send", send, 1'b1);
        chk("post_rst_txin", Tx_in, 8'h3C);

        // stalled transmitter keeps Tx_ready high during SEND
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        chk("stall_send", send, 1'b1);
        chk("stall_txin", Tx_in, 8'h3C);
        chk("stall_count", count, 3);
        drain(3);
        chk("sb_left", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
